imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the byte-wide, little-endian instruction memory: streams 32-bit
//  program words in over a valid/ready handshake and commits each as 4 byte writes.
//  Sits between the host/boot stream and the imem write port; holds the RISC-V core
//  in reset until a program image is fully loaded.
// PARAMETERS
//  ADDR_WIDTH  16          byte-address width of instruction memory (2^16 bytes)
//  BASE_ADDR   0           byte address of first loaded word (must be 4-aligned)
//  MAX_WORDS   2^(ADDR_WIDTH-2)  word capacity; words beyond this are dropped
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           async active-low reset
//  start        in   1           pulse: begin a load session (ignored while busy)
//  in_valid     in   1           in_data/in_last valid
//  in_data      in   32          program word, byte0 = in_data[7:0]
//  in_last      in   1           qualifies final word of the image
//  in_ready     out  1           loader can accept a word
//  mem_we       out  1           byte write enable to imem
//  mem_addr     out  ADDR_WIDTH  byte address of write
//  mem_wdata    out  8           byte to write
//  busy         out  1           session in progress
//  done         out  1           image loaded (level, until next start)
//  overflow     out  1           sticky: a word was dropped for capacity
//  word_count   out  ADDR_WIDTH-1  words committed this session
//  cpu_rst_hold out  1           1 = hold core in reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_ready=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, busy=0, done=0, overflow=0, word_count=0, cpu_rst_hold=1.
//  FSM states IDLE, WAIT, WRITE, DONE; byte_idx 2-bit counter; word_addr register.
//  IDLE: start=1 -> WAIT; word_addr<=BASE_ADDR, word_count<=0, overflow<=0.
//  WAIT: in_ready=1, busy=1. in_valid=1 is a handshake in the same cycle:
//   capture in_data/in_last, byte_idx<=0 -> WRITE. If word_count==MAX_WORDS the
//   word is consumed but discarded, overflow<=1; in_last -> DONE else stay WAIT.
//  WRITE: in_ready=0, mem_we=1, mem_addr=word_addr+byte_idx,
//   mem_wdata=captured[8*byte_idx+:8]; 4 cycles, byte_idx 0..3.
//   After byte 3: word_addr+=4, word_count+=1; last -> DONE else -> WAIT.
//  DONE: done=1, busy=0, cpu_rst_hold=0, in_ready=0; start=1 -> WAIT (new session,
//   done<=0, cpu_rst_hold<=1, counters cleared as in IDLE).
//  cpu_rst_hold=1 in every state except DONE.
//  mem_we/mem_addr/mem_wdata decode from registered state only (no in_* path);
//   mem_we=0 outside WRITE, mem_addr/mem_wdata hold last value.
//  Throughput: 5 cycles/word with in_valid held high (1 WAIT + 4 WRITE).
//  Latency: handshake edge -> first mem_we cycle = 1 cycle.
//  word_addr wraps modulo 2^ADDR_WIDTH (cannot occur when BASE_ADDR=0).
//  start while busy: ignored. in_valid outside WAIT: ignored (no handshake).
//  rst_n low mid-WRITE: immediate return to reset values; partial word may remain
//   in imem; core re-held.
// TESTING
//  1. Reset, start, one word 0x00500093 with last -> writes 93,00,50,00 at addr
//     0..3 on 4 consecutive cycles; done=1, word_count=1, cpu_rst_hold falls.
//  2. 3 back-to-back words, in_valid held high -> in_ready pulses every 5 cycles,
//     last byte at addr 11, word_count=3.
//  3. in_valid gaps of 0..7 cycles between words -> loader idles in WAIT, no mem_we,
//     image identical to test 2.
//  4. MAX_WORDS=4, send 6 words, last on 6th -> only addr 0..15 written, overflow=1,
//     done=1, word_count=4.
//  5. rst_n low during byte 2 of word 1 -> all outputs at reset values same cycle;
//     new start reloads from BASE_ADDR.
//  6. start pulsed mid-session and in DONE -> ignored vs. restart (done=0, count=0).

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the byte-wide, little-endian instruction memory. Program
// words arrive 32 bits at a time over a valid/ready stream and are committed
// to the memory as four consecutive byte writes (byte 0 = in_data[7:0] at the
// lowest address). While an image is being loaded the RISC-V core is held in
// reset; the hold is released only once the word flagged in_last has been
// fully written (or dropped for lack of capacity).
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         pulse: begin a load session (ignored while a session is busy)
//   in_valid      in_data / in_last are valid
//   in_data       32-bit program word, byte 0 = in_data[7:0]
//   in_last       marks the final word of the image
//   in_ready      loader can accept a word this cycle
//   mem_we        byte write enable to imem
//   mem_addr      byte address of the write
//   mem_wdata     byte to write
//   busy          a session is in progress (WAIT or WRITE)
//   done          image loaded; level, cleared by the next accepted start
//   overflow      sticky per session: a word was dropped for capacity
//   word_count    words committed in the current session
//   cpu_rst_hold  1 = keep the core in reset (every state except DONE)
//   fsm_state     current FSM state, for observation only
//
// Stream handshake: a word transfers on a rising clock edge where in_valid
// and in_ready are both 1. in_ready is a registered output that is 1 only in
// WAIT, so it never depends combinationally on in_valid; the source must hold
// in_data/in_last stable while in_valid is 1 and in_ready is 0.
//
// Every output is a register. mem_we/mem_addr/mem_wdata are loaded from
// internal state on the edge that enters or advances WRITE, so there is no
// combinational path from the in_* inputs to the memory port, and the first
// byte write appears in the cycle right after the handshake edge. Outside
// WRITE mem_addr/mem_wdata keep the last byte written.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH-2:0] word_count,
    output logic                  cpu_rst_hold,
    output logic [1:0]            fsm_state
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-2:0] CAPACITY = (ADDR_WIDTH - 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WORD_INC = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-2:0] CNT_ONE  = (ADDR_WIDTH - 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [1:0]              byte_idx;   // byte of word_buf currently on the memory port
    logic [ADDR_WIDTH-1:0]   word_addr;  // byte address of the word being written
    logic [31:0]             word_buf;   // word captured at the handshake
    logic                    last_q;     // captured in_last of that word
    logic [1:0]              next_idx;

    assign next_idx  = byte_idx + 2'd1;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            byte_idx     <= 2'd0;
            word_addr    <= BASE;
            word_buf     <= 32'd0;
            last_q       <= 1'b0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            word_count   <= '0;
            cpu_rst_hold <= 1'b1;
        end else begin
            case (state)
                // IDLE and DONE both wait for start; DONE additionally has to
                // drop done and re-hold the core, which is harmless from IDLE.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_WAIT;
                        word_addr    <= BASE;
                        word_count   <= '0;
                        overflow     <= 1'b0;
                        done         <= 1'b0;
                        cpu_rst_hold <= 1'b1;
                        busy         <= 1'b1;
                        in_ready     <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (in_valid) begin
                        if (word_count == CAPACITY) begin
                            // Memory is full: the word is accepted off the
                            // stream so the source never stalls, but dropped.
                            overflow <= 1'b1;
                            if (in_last) begin
                                state        <= S_DONE;
                                in_ready     <= 1'b0;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                                cpu_rst_hold <= 1'b0;
                            end
                        end else begin
                            word_buf  <= in_data;
                            last_q    <= in_last;
                            byte_idx  <= 2'd0;
                            state     <= S_WRITE;
                            in_ready  <= 1'b0;
                            // Byte 0 goes out in the very next cycle.
                            mem_we    <= 1'b1;
                            mem_addr  <= word_addr;
                            mem_wdata <= in_data[7:0];
                        end
                    end
                end

                S_WRITE: begin
                    if (byte_idx == 2'd3) begin
                        mem_we     <= 1'b0;
                        word_addr  <= word_addr + WORD_INC;
                        word_count <= word_count + CNT_ONE;
                        if (last_q) begin
                            state        <= S_DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_rst_hold <= 1'b0;
                        end else begin
                            state    <= S_WAIT;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        byte_idx  <= next_idx;
                        mem_addr  <= word_addr + ADDR_WIDTH'(next_idx);
                        mem_wdata <= word_buf[{next_idx, 3'b000} +: 8];
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
